// File: rtl/sample_stream_reader_if.sv
// Memory read port and output sample stream of the sample stream reader.
// master = reader side, slave = memory/downstream side.
interface sample_stream_reader_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
) ();
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;

   modport master (
      output mem_addr,
      input  mem_rdata,
      output out_valid,
      output out_data,
      input  out_ready
   );

   modport slave (
      input  mem_addr,
      output mem_rdata,
      input  out_valid,
      input  out_data,
      output out_ready
   );
endinterface

// File: rtl/sample_stream_reader.sv
// Streams a window of the sample memory out through a small prefetch buffer.
// Define READER_CHECKSUM_EN to add the running `checksum` output.
module sample_stream_reader #(
   parameter int unsigned ADDR_W     = 4,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     start_addr,
   input  logic [ADDR_W:0]       length,
   input  logic                  loop_en,
   input  logic                  abort,
   sample_stream_reader_if.master bus,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W:0]       sample_cnt
`ifdef READER_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0]     checksum
`endif
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CntW:0]     DepthOcc = (CntW + 1)'(FIFO_DEPTH);
   localparam logic [PtrW-1:0]   LastPtr  = PtrW'(FIFO_DEPTH - 1);
   localparam logic [PtrW-1:0]   PtrOne   = PtrW'(1);
   localparam logic [ADDR_W:0]   LenOne   = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);

   typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
   logic [ADDR_W:0]   sample_cnt_q, sample_cnt_d;
   logic              loop_q, loop_d;
   logic              inflight_q, inflight_d;
   logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_d [FIFO_DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
`ifdef READER_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_q, checksum_d;
`endif

   logic            pop, push, issue, accept, kill;
   logic [CntW:0]   occ;

   always_comb begin
      pop    = (count_q != '0) && bus.out_ready;
      accept = (state_q == StIdle) && start && !abort;
      kill   = abort && (state_q != StDone);
      // Occupancy after this cycle's pop, counting the read still in flight.
      occ    = {1'b0, count_q} + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
      issue  = (state_q == StFetch) && !abort && (occ < DepthOcc);
      push   = inflight_q && !kill;

      state_d      = state_q;
      mem_addr_d   = mem_addr_q;
      base_d       = base_q;
      len_d        = len_q;
      issue_cnt_d  = issue_cnt_q;
      sample_cnt_d = sample_cnt_q;
      loop_d       = loop_q;
      inflight_d   = issue;
      fifo_d       = fifo_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q + CntW'(push) - CntW'(pop);
`ifdef READER_CHECKSUM_EN
      checksum_d   = checksum_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               base_d      = start_addr;
               len_d       = length;
               loop_d      = loop_en;
               issue_cnt_d = '0;
               if (length == '0) begin
                  state_d = StDone;
               end else begin
                  state_d    = StFetch;
                  mem_addr_d = start_addr;
               end
            end
         end
         StFetch: begin
            if (issue) begin
               if (issue_cnt_q + LenOne == len_q) begin
                  if (loop_q) begin
                     issue_cnt_d = '0;
                     mem_addr_d  = base_q;
                  end else begin
                     state_d = StDrain;
                  end
               end else begin
                  issue_cnt_d = issue_cnt_q + LenOne;
                  mem_addr_d  = mem_addr_q + AddrOne;
               end
            end
         end
         StDrain: begin
            if (!inflight_q && (count_q == CntW'(pop))) state_d = StDone;
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (pop) begin
         sample_cnt_d = (loop_q && (sample_cnt_q + LenOne == len_q)) ? '0
                                                                     : sample_cnt_q + LenOne;
`ifdef READER_CHECKSUM_EN
         checksum_d   = checksum_q + bus.out_data;
`endif
      end
      if (accept) begin
         sample_cnt_d = '0;
`ifdef READER_CHECKSUM_EN
         checksum_d   = '0;
`endif
      end

      if (push) begin
         fifo_d[wr_ptr_q] = bus.mem_rdata;
         wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrOne;
      end
      if (pop) rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrOne;

      if (kill) begin
         state_d    = StIdle;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         inflight_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         mem_addr_q   <= '0;
         base_q       <= '0;
         len_q        <= '0;
         issue_cnt_q  <= '0;
         sample_cnt_q <= '0;
         loop_q       <= 1'b0;
         inflight_q   <= 1'b0;
         fifo_q       <= '{default: '0};
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
`ifdef READER_CHECKSUM_EN
         checksum_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         mem_addr_q   <= mem_addr_d;
         base_q       <= base_d;
         len_q        <= len_d;
         issue_cnt_q  <= issue_cnt_d;
         sample_cnt_q <= sample_cnt_d;
         loop_q       <= loop_d;
         inflight_q   <= inflight_d;
         fifo_q       <= fifo_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
`ifdef READER_CHECKSUM_EN
         checksum_q   <= checksum_d;
`endif
      end
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.out_valid = (count_q != '0);
   assign bus.out_data  = fifo_q[rd_ptr_q];
   assign busy          = (state_q == StFetch) || (state_q == StDrain);
   assign done          = (state_q == StDone);
   assign sample_cnt    = sample_cnt_q;
`ifdef READER_CHECKSUM_EN
   assign checksum      = checksum_q;
`endif

endmodule
